// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC channel scheduler: FSM state encoding,
// the fixed-point 1.0 gain value and the channel-index width helper.
package dac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CONVERT,
    WRITE,
    SETTLE
  } sched_state_e;

  // 1.0 in the default Q16.48 fixed-point format
  localparam logic [63:0] FP_ONE = 64'h0001_0000_0000_0000;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dac_rr_pick.sv
// Combinational round-robin finder: returns the first set bit of 'dirty' at or
// after 'ptr', wrapping past N_CH-1 back to 0.
module dac_rr_pick
  import dac_sched_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] dirty,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] idx,
  output logic            found
);

  int              cand;
  logic [CH_W-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      cand_idx = CH_W'(cand);
      if (!found && dirty[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dac_channel_scheduler.sv
// Time-shares one external fixed-point -> DAC-code datapath across N_CH channels.
// Optional macro DAC_SCHED_COALESCE_EN: never backpressure, later setpoints overwrite pending ones.
module dac_channel_scheduler
  import dac_sched_pkg::*;
#(
  parameter  int FP_WIDTH      = 64,
  parameter  int INT_WIDTH     = 16,
  parameter  int DAC_WIDTH     = 14,
  parameter  int N_CH          = 8,
  parameter  int CONV_LAT      = 2,
  parameter  int SETTLE_CYCLES = 4,
  localparam int CH_W          = ch_w(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_ch,
  input  logic [FP_WIDTH-1:0]  in_fp,
  input  logic                 cal_we,
  input  logic [CH_W-1:0]      cal_ch,
  input  logic [FP_WIDTH-1:0]  cal_gain,
  input  logic [FP_WIDTH-1:0]  cal_offset,
  output logic [FP_WIDTH-1:0]  conv_fp,
  output logic [FP_WIDTH-1:0]  conv_gain,
  output logic [FP_WIDTH-1:0]  conv_offset,
  input  logic [DAC_WIDTH-1:0] conv_code,
  output logic [CH_W-1:0]      dac_addr,
  output logic [DAC_WIDTH-1:0] dac_data,
  output logic                 dac_wr,
  output logic                 busy
);

  localparam logic [FP_WIDTH-1:0] GAIN_ONE =
    {{(FP_WIDTH-1){1'b0}}, 1'b1} << (FP_WIDTH - INT_WIDTH);
  localparam int CNT_MAX = (CONV_LAT > SETTLE_CYCLES) ? CONV_LAT : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]      sel_q, sel_d;
  logic [CH_W-1:0]      rr_q, rr_d;
  logic [N_CH-1:0]      dirty_q, dirty_d;
  logic [FP_WIDTH-1:0]  sp_q     [N_CH];
  logic [FP_WIDTH-1:0]  sp_d     [N_CH];
  logic [FP_WIDTH-1:0]  gain_q   [N_CH];
  logic [FP_WIDTH-1:0]  gain_d   [N_CH];
  logic [FP_WIDTH-1:0]  offset_q [N_CH];
  logic [FP_WIDTH-1:0]  offset_d [N_CH];
  logic [FP_WIDTH-1:0]  conv_fp_q, conv_fp_d;
  logic [FP_WIDTH-1:0]  conv_gain_q, conv_gain_d;
  logic [FP_WIDTH-1:0]  conv_offset_q, conv_offset_d;
  logic [CH_W-1:0]      dac_addr_q, dac_addr_d;
  logic [DAC_WIDTH-1:0] dac_data_q, dac_data_d;
  logic                 dac_wr_q, dac_wr_d;

  logic [CH_W-1:0] pick_idx;
  logic            pick_found;
  logic            accept;

  dac_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .dirty (dirty_q),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef DAC_SCHED_COALESCE_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = ~dirty_q[in_ch];
`endif

  assign accept      = in_valid & in_ready;
  assign busy        = (state_q != IDLE) || (|dirty_q);
  assign conv_fp     = conv_fp_q;
  assign conv_gain   = conv_gain_q;
  assign conv_offset = conv_offset_q;
  assign dac_addr    = dac_addr_q;
  assign dac_data    = dac_data_q;
  assign dac_wr      = dac_wr_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    dirty_d       = dirty_q;
    sp_d          = sp_q;
    gain_d        = gain_q;
    offset_d      = offset_q;
    conv_fp_d     = conv_fp_q;
    conv_gain_d   = conv_gain_q;
    conv_offset_d = conv_offset_q;
    dac_addr_d    = dac_addr_q;
    dac_data_d    = dac_data_q;
    dac_wr_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|dirty_q) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (pick_found) begin
          sel_d             = pick_idx;
          conv_fp_d         = sp_q[pick_idx];
          conv_gain_d       = gain_q[pick_idx];
          conv_offset_d     = offset_q[pick_idx];
          dirty_d[pick_idx] = 1'b0;
          cnt_d             = '0;
          state_d           = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        if (cnt_q == CNT_W'(CONV_LAT - 1)) begin
          cnt_d   = '0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        dac_wr_d   = 1'b1;
        dac_addr_d = sel_q;
        dac_data_d = conv_code;
        rr_d       = (sel_q == CH_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
        cnt_d      = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (|dirty_q) ? SELECT : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new setpoint arriving on the channel being cleared in SELECT must stay pending
    if (accept) begin
      sp_d[in_ch]    = in_fp;
      dirty_d[in_ch] = 1'b1;
    end
    if (cal_we) begin
      gain_d[cal_ch]   = cal_gain;
      offset_d[cal_ch] = cal_offset;
    end
  end

  // conv_gain comes out of reset at 1.0 to match the per-channel gain registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      rr_q          <= '0;
      dirty_q       <= '0;
      conv_fp_q     <= '0;
      conv_gain_q   <= GAIN_ONE;
      conv_offset_q <= '0;
      dac_addr_q    <= '0;
      dac_data_q    <= '0;
      dac_wr_q      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        sp_q[i]     <= '0;
        gain_q[i]   <= GAIN_ONE;
        offset_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      rr_q          <= rr_d;
      dirty_q       <= dirty_d;
      conv_fp_q     <= conv_fp_d;
      conv_gain_q   <= conv_gain_d;
      conv_offset_q <= conv_offset_d;
      dac_addr_q    <= dac_addr_d;
      dac_data_q    <= dac_data_d;
      dac_wr_q      <= dac_wr_d;
      sp_q          <= sp_d;
      gain_q        <= gain_d;
      offset_q      <= offset_d;
    end
  end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Self-checking bench for dac_channel_scheduler: directed scenarios plus random
// traffic checked against a queue-based model of pending setpoints and cal writes.
module tb_dac_channel_scheduler;
  import dac_sched_pkg::*;

  localparam int N_CH     = 8;
  localparam int CONV_LAT = 2;
  localparam int SPACING  = 1 + CONV_LAT + 1 + 4;
  localparam logic [63:0] GAIN_TWO = 64'h0002_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ch;
  logic [63:0] in_fp;
  logic        cal_we;
  logic [2:0]  cal_ch;
  logic [63:0] cal_gain;
  logic [63:0] cal_offset;
  logic [63:0] conv_fp;
  logic [63:0] conv_gain;
  logic [63:0] conv_offset;
  logic [13:0] conv_code;
  logic [2:0]  dac_addr;
  logic [13:0] dac_data;
  logic        dac_wr;
  logic        busy;

  dac_channel_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_fp       (in_fp),
    .cal_we      (cal_we),
    .cal_ch      (cal_ch),
    .cal_gain    (cal_gain),
    .cal_offset  (cal_offset),
    .conv_fp     (conv_fp),
    .conv_gain   (conv_gain),
    .conv_offset (conv_offset),
    .conv_code   (conv_code),
    .dac_addr    (dac_addr),
    .dac_data    (dac_data),
    .dac_wr      (dac_wr),
    .busy        (busy)
  );

  typedef struct { int e; int ch; logic [63:0] v; } acc_t;
  typedef struct { int e; int ch; logic [63:0] g; logic [63:0] o; } cal_t;
  typedef struct { int e; int addr; logic [13:0] data; } wr_t;

  acc_t acc_q[$];
  cal_t cal_q[$];
  wr_t  wr_log[$];
  int   rr_m = 0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [13:0] pipe1 = '0;

  function automatic logic [13:0] code_fn(input logic [63:0] fp, input logic [63:0] g,
                                          input logic [63:0] o);
    return fp[47:34] + g[49:36] + o[13:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: after posedge k the counter reads k
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external conversion pipeline, CONV_LAT register stages deep
  always @(posedge clk) begin
    pipe1     <= code_fn(conv_fp, conv_gain, conv_offset);
    conv_code <= pipe1;
  end

  // Reference model: a write after edge n converts what was pending and calibrated
  // by edge n-2-CONV_LAT, chosen round-robin from the last written channel + 1.
  task automatic modelWrite();
    int t = cyc - 2 - CONV_LAT;
    int pick = -1;
    logic [63:0] v = '0;
    logic [63:0] g = FP_ONE;
    logic [63:0] o = '0;
    for (int k = 0; k < N_CH && pick < 0; k++) begin
      int c = (rr_m + k) % N_CH;
      for (int j = 0; j < acc_q.size(); j++) begin
        if (acc_q[j].ch == c) begin
          if (acc_q[j].e <= t) pick = c;
          break;
        end
      end
    end
    n_assert++;
    assert (pick >= 0)
    else begin
      n_fail++;
      $error("[TB] FAIL wr_unexpected: write to addr %0d at cycle %0d, model has none eligible",
             dac_addr, cyc);
    end
    if (pick >= 0) begin
      for (int j = 0; j < acc_q.size(); j++)
        if (acc_q[j].ch == pick && acc_q[j].e <= t) v = acc_q[j].v;
      for (int j = acc_q.size() - 1; j >= 0; j--)
        if (acc_q[j].ch == pick && acc_q[j].e <= t) acc_q.delete(j);
      foreach (cal_q[j])
        if (cal_q[j].ch == pick && cal_q[j].e <= t) begin
          g = cal_q[j].g;
          o = cal_q[j].o;
        end
      checkOutput("wr_addr", 64'(dac_addr), 64'(pick));
      checkOutput("wr_data", 64'(dac_data), 64'(code_fn(v, g, o)));
      rr_m = (pick + 1) % N_CH;
    end
    wr_log.push_back('{cyc, int'(dac_addr), dac_data});
  endtask

  // Monitor on the falling edge: score writes, then log inputs the next edge will take
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      cal_q.delete();
      rr_m = 0;
    end else begin
      if (dac_wr) modelWrite();
      if (in_valid && in_ready) acc_q.push_back('{cyc + 1, int'(in_ch), in_fp});
      if (cal_we) cal_q.push_back('{cyc + 1, int'(cal_ch), cal_gain, cal_offset});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one setpoint, wait (bounded) for in_ready, return the accepting edge index
  task automatic applyStimulus(input int ch, input logic [63:0] fp, output int acc_e);
    int w = 0;
    in_valid = 1'b1;
    in_ch    = 3'(ch);
    in_fp    = fp;
    #1;
    while (!in_ready && w < 40) begin
      tick();
      #1;
      w++;
    end
    if (w >= 40) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    acc_e    = cyc;
    in_valid = 1'b0;
  endtask

  task automatic waitWrites(input int n, input string tag);
    int w = 0;
    while (wr_log.size() < n && w < 150) begin
      tick();
      w++;
    end
    checkOutput({tag, "_count"}, 64'(wr_log.size()), 64'(n));
  endtask

  task automatic waitIdle(input string tag);
    int w = 0;
    while (busy && w < 300) begin
      tick();
      w++;
    end
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Directed scenarios first, then random traffic, then a final drain
  initial begin
    int e0;
    int w;
    logic [63:0] v1;
    logic [63:0] v2;

    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_fp = '0;
    cal_we = 1'b0; cal_ch = '0; cal_gain = '0; cal_offset = '0;
    $display("[TB] start");
    repeat (3) tick();
    checkOutput("rst_dac_wr", 64'(dac_wr), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_conv_fp", conv_fp, 64'd0);
    checkOutput("rst_conv_gain", conv_gain, FP_ONE);
    checkOutput("rst_conv_offset", conv_offset, 64'd0);
    checkOutput("rst_dac_addr", 64'(dac_addr), 64'd0);
    checkOutput("rst_dac_data", 64'(dac_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single write, latency from accept to strobe
    wr_log.delete();
    v1 = 64'h0001_8000_0000_0000;
    applyStimulus(3, v1, e0);
    waitWrites(1, "single");
    if (wr_log.size() >= 1) begin
      checkOutput("single_latency", 64'(wr_log[0].e - e0), 64'd5);
      checkOutput("single_addr", 64'(wr_log[0].addr), 64'd3);
      checkOutput("single_data", 64'(wr_log[0].data), 64'(code_fn(v1, FP_ONE, 64'd0)));
    end
    checkOutput("single_conv_fp", conv_fp, v1);
    tick();
    checkOutput("single_one_pulse", 64'(dac_wr), 64'd0);
    waitIdle("single");

    // Back-to-back writes on all channels
    wr_log.delete();
    for (int i = 0; i < N_CH; i++) applyStimulus(i, {$urandom, $urandom}, e0);
    waitWrites(N_CH, "b2b");
    if (wr_log.size() >= N_CH) begin
      for (int i = 0; i < N_CH; i++) checkOutput("b2b_order", 64'(wr_log[i].addr), 64'(i));
      for (int i = 1; i < N_CH; i++)
        checkOutput("b2b_spacing", 64'(wr_log[i].e - wr_log[i-1].e), 64'(SPACING));
    end
    waitIdle("b2b");

    // Second setpoint on a channel that is still pending
    wr_log.delete();
    v1 = {$urandom, $urandom};
    v2 = {$urandom, $urandom};
    applyStimulus(1, v1, e0);
    in_valid = 1'b1; in_ch = 3'd1; in_fp = v2;
    #1;
`ifdef DAC_SCHED_COALESCE_EN
    checkOutput("coal_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    waitIdle("coal");
    checkOutput("coal_writes", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() >= 1)
      checkOutput("coal_data", 64'(wr_log[0].data), 64'(code_fn(v2, FP_ONE, 64'd0)));
`else
    checkOutput("stall_ready", 64'(in_ready), 64'd0);
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      #1;
      w++;
    end
    checkOutput("stall_release_cycle", 64'(cyc - e0), 64'd2);
    tick();
    in_valid = 1'b0;
    waitWrites(2, "stall");
    if (wr_log.size() >= 2) begin
      checkOutput("stall_first_data", 64'(wr_log[0].data), 64'(code_fn(v1, FP_ONE, 64'd0)));
      checkOutput("stall_second_data", 64'(wr_log[1].data), 64'(code_fn(v2, FP_ONE, 64'd0)));
    end
    waitIdle("stall");
`endif

    // Calibration write while the same channel is converting
    wr_log.delete();
    v1 = {$urandom, $urandom};
    v2 = {$urandom, $urandom};
    applyStimulus(2, v1, e0);
    tick();
    tick();
    cal_we = 1'b1; cal_ch = 3'd2; cal_gain = GAIN_TWO; cal_offset = 64'h55;
    tick();
    cal_we = 1'b0;
    waitWrites(1, "cal_inflight");
    if (wr_log.size() >= 1)
      checkOutput("cal_old_gain_data", 64'(wr_log[0].data), 64'(code_fn(v1, FP_ONE, 64'd0)));
    checkOutput("cal_old_conv_gain", conv_gain, FP_ONE);
    waitIdle("cal_inflight");
    wr_log.delete();
    applyStimulus(2, v2, e0);
    waitWrites(1, "cal_next");
    if (wr_log.size() >= 1)
      checkOutput("cal_new_gain_data", 64'(wr_log[0].data), 64'(code_fn(v2, GAIN_TWO, 64'h55)));
    checkOutput("cal_new_conv_gain", conv_gain, GAIN_TWO);
    waitIdle("cal_next");

    // Reset asserted mid-conversion
    wr_log.delete();
    applyStimulus(5, {$urandom, $urandom}, e0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_dac_wr", 64'(dac_wr), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("abort_no_write", 64'(wr_log.size()), 64'd0);
    checkOutput("abort_conv_gain", conv_gain, FP_ONE);
    checkOutput("abort_conv_fp", conv_fp, 64'd0);
    checkOutput("abort_busy_after", 64'(busy), 64'd0);
    in_ch = 3'd5;
    #1;
    checkOutput("abort_dirty_cleared", 64'(in_ready), 64'd1);

    // Round-robin pointer left at 5, then channels 2 and 6 pending together
    applyStimulus(4, {$urandom, $urandom}, e0);
    waitIdle("rr_setup");
    wr_log.delete();
    applyStimulus(2, {$urandom, $urandom}, e0);
    applyStimulus(6, {$urandom, $urandom}, e0);
    waitWrites(2, "rr");
    if (wr_log.size() >= 2) begin
      checkOutput("rr_first", 64'(wr_log[0].addr), 64'd6);
      checkOutput("rr_second", 64'(wr_log[1].addr), 64'd2);
    end
    waitIdle("rr");

    // Random setpoint and calibration traffic
    for (int i = 0; i < 300; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_ch      = 3'($urandom_range(0, 7));
      in_fp      = {$urandom, $urandom};
      cal_we     = ($urandom_range(0, 15) == 0);
      cal_ch     = 3'($urandom_range(0, 7));
      cal_gain   = {$urandom, $urandom};
      cal_offset = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    cal_we   = 1'b0;
    waitIdle("random");
    checkOutput("random_drained", 64'(acc_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
